// File: rtl/counter_sequence_checker_pkg.sv
// Shared state encoding for the counter sequence checker.
package counter_sequence_checker_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

endpackage

// File: rtl/counter_sequence_checker_sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones.
// Registered output; the count moves on the same edge as the pulse it counts.
module counter_sequence_checker_sat_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_WIDTH{1'b1}})) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/counter_sequence_checker.sv
// Locks onto a counter stream advancing by STEP, flags deviations and wrap-arounds,
// and re-emits each sample resized to OUT_WIDTH. All outputs respond one edge after sample_valid.
module counter_sequence_checker
  import counter_sequence_checker_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int SIGNED     = 0,
  parameter int STEP       = 1,
  parameter int LOCK_COUNT = 3,
  parameter int OUT_WIDTH  = 9,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_valid,
  input  logic [WIDTH-1:0]     sample_data,
  output logic                 locked,
  output logic                 error_pulse,
  output logic                 wrap_pulse,
  output logic [CNT_WIDTH-1:0] error_count,
  output logic [CNT_WIDTH-1:0] wrap_count,
  output logic [OUT_WIDTH-1:0] out_value,
  output logic [WIDTH-1:0]     expected
);

  localparam int                MC_W   = $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0]  STEP_V = WIDTH'(STEP);
  localparam logic [MC_W-1:0]   LOCK_V = MC_W'(LOCK_COUNT);

  state_e                 state_q, state_d;
  logic [MC_W-1:0]        match_cnt_q, match_cnt_d;
  logic [WIDTH-1:0]       expected_q, expected_d;
  logic [OUT_WIDTH-1:0]   out_value_q, out_value_d;
  logic                   error_pulse_q, error_pulse_d;
  logic                   wrap_pulse_q, wrap_pulse_d;

  logic [OUT_WIDTH-1:0]   resized;
  logic [WIDTH-1:0]       next_exp;
  logic [WIDTH-1:0]       prev_sample;
  logic                   matched;
  logic                   wrapped;

  generate
    if (OUT_WIDTH <= WIDTH) begin : g_trunc
      assign resized = sample_data[OUT_WIDTH-1:0];
    end else if (SIGNED != 0) begin : g_sext
      assign resized = {{(OUT_WIDTH-WIDTH){sample_data[WIDTH-1]}}, sample_data};
    end else begin : g_zext
      assign resized = {{(OUT_WIDTH-WIDTH){1'b0}}, sample_data};
    end
  endgenerate

  // While locked, expected_q is always last sample + STEP, so the previous sample is recoverable.
  assign next_exp    = sample_data + STEP_V;
  assign prev_sample = expected_q - STEP_V;
  assign matched     = (sample_data == expected_q);
  assign wrapped     = (SIGNED != 0) ? (!prev_sample[WIDTH-1] && sample_data[WIDTH-1])
                                     : (sample_data < prev_sample);

  always_comb begin
    state_d       = state_q;
    match_cnt_d   = match_cnt_q;
    expected_d    = expected_q;
    out_value_d   = out_value_q;
    error_pulse_d = 1'b0;
    wrap_pulse_d  = 1'b0;
    if (sample_valid) begin
      out_value_d = resized;
      // A match means sample == expected, so every branch advances from the sample itself.
      expected_d  = next_exp;
      case (state_q)
        ST_IDLE: begin
          match_cnt_d = '0;
          if (LOCK_COUNT == 1) state_d = ST_LOCKED;
          else                 state_d = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          if (matched) begin
            match_cnt_d = match_cnt_q + MC_W'(1);
            if (match_cnt_d == LOCK_V) state_d = ST_LOCKED;
          end else begin
            match_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          if (matched) begin
            wrap_pulse_d = wrapped;
          end else begin
            error_pulse_d = 1'b1;
            match_cnt_d   = '0;
            state_d       = ST_ACQUIRE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      match_cnt_q   <= '0;
      expected_q    <= '0;
      out_value_q   <= '0;
      error_pulse_q <= 1'b0;
      wrap_pulse_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      match_cnt_q   <= match_cnt_d;
      expected_q    <= expected_d;
      out_value_q   <= out_value_d;
      error_pulse_q <= error_pulse_d;
      wrap_pulse_q  <= wrap_pulse_d;
    end
  end

  counter_sequence_checker_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (error_pulse_d),
    .count (error_count)
  );

  counter_sequence_checker_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_wrap_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (wrap_pulse_d),
    .count (wrap_count)
  );

  assign locked      = (state_q == ST_LOCKED);
  assign error_pulse = error_pulse_q;
  assign wrap_pulse  = wrap_pulse_q;
  assign out_value   = out_value_q;
  assign expected    = expected_q;

endmodule

// File: tb/tb_counter_sequence_checker.sv
// Drives four differently parameterised checkers with directed and random counter streams
// and compares every output against a behavioural model each cycle.
module tb_counter_sequence_checker;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sample_valid = 1'b0;
  logic [15:0] da = '0;
  logic [3:0]  db = '0;
  logic [2:0]  dc = '0;
  logic [7:0]  dd = '0;

  always #5 clk = ~clk;

  // Instance configs: A default, B signed 4-bit, C 3-bit lock-on-first, D step 5.
  int cfg_w [4] = '{16, 4, 3, 8};
  int cfg_s [4] = '{0, 1, 0, 0};
  int cfg_st[4] = '{1, 1, 1, 5};
  int cfg_lc[4] = '{3, 3, 1, 2};
  int cfg_ow[4] = '{9, 10, 2, 12};
  int cfg_cw[4] = '{8, 2, 8, 3};

  logic        lk_a, ep_a, wp_a;  logic [7:0] ec_a, wc_a;  logic [8:0]  ov_a;  logic [15:0] ex_a;
  logic        lk_b, ep_b, wp_b;  logic [1:0] ec_b, wc_b;  logic [9:0]  ov_b;  logic [3:0]  ex_b;
  logic        lk_c, ep_c, wp_c;  logic [7:0] ec_c, wc_c;  logic [1:0]  ov_c;  logic [2:0]  ex_c;
  logic        lk_d, ep_d, wp_d;  logic [2:0] ec_d, wc_d;  logic [11:0] ov_d;  logic [7:0]  ex_d;

  counter_sequence_checker u_a (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_data(da),
    .locked(lk_a), .error_pulse(ep_a), .wrap_pulse(wp_a), .error_count(ec_a),
    .wrap_count(wc_a), .out_value(ov_a), .expected(ex_a));

  counter_sequence_checker #(.WIDTH(4), .SIGNED(1), .STEP(1), .LOCK_COUNT(3), .OUT_WIDTH(10), .CNT_WIDTH(2)) u_b (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_data(db),
    .locked(lk_b), .error_pulse(ep_b), .wrap_pulse(wp_b), .error_count(ec_b),
    .wrap_count(wc_b), .out_value(ov_b), .expected(ex_b));

  counter_sequence_checker #(.WIDTH(3), .SIGNED(0), .STEP(1), .LOCK_COUNT(1), .OUT_WIDTH(2), .CNT_WIDTH(8)) u_c (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_data(dc),
    .locked(lk_c), .error_pulse(ep_c), .wrap_pulse(wp_c), .error_count(ec_c),
    .wrap_count(wc_c), .out_value(ov_c), .expected(ex_c));

  counter_sequence_checker #(.WIDTH(8), .SIGNED(0), .STEP(5), .LOCK_COUNT(2), .OUT_WIDTH(12), .CNT_WIDTH(3)) u_d (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_data(dd),
    .locked(lk_d), .error_pulse(ep_d), .wrap_pulse(wp_d), .error_count(ec_d),
    .wrap_count(wc_d), .out_value(ov_d), .expected(ex_d));

  logic [31:0] o_lk[4], o_ep[4], o_wp[4], o_ec[4], o_wc[4], o_ov[4], o_ex[4];
  assign o_lk[0] = 32'(lk_a); assign o_ep[0] = 32'(ep_a); assign o_wp[0] = 32'(wp_a);
  assign o_ec[0] = 32'(ec_a); assign o_wc[0] = 32'(wc_a); assign o_ov[0] = 32'(ov_a); assign o_ex[0] = 32'(ex_a);
  assign o_lk[1] = 32'(lk_b); assign o_ep[1] = 32'(ep_b); assign o_wp[1] = 32'(wp_b);
  assign o_ec[1] = 32'(ec_b); assign o_wc[1] = 32'(wc_b); assign o_ov[1] = 32'(ov_b); assign o_ex[1] = 32'(ex_b);
  assign o_lk[2] = 32'(lk_c); assign o_ep[2] = 32'(ep_c); assign o_wp[2] = 32'(wp_c);
  assign o_ec[2] = 32'(ec_c); assign o_wc[2] = 32'(wc_c); assign o_ov[2] = 32'(ov_c); assign o_ex[2] = 32'(ex_c);
  assign o_lk[3] = 32'(lk_d); assign o_ep[3] = 32'(ep_d); assign o_wp[3] = 32'(wp_d);
  assign o_ec[3] = 32'(ec_d); assign o_wc[3] = 32'(wc_d); assign o_ov[3] = 32'(ov_d); assign o_ex[3] = 32'(ex_d);

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: "based" = a reference sample exists, "run" = matches since that reference.
  bit based[4], lk[4], errp[4], wrapp[4];
  int run[4], exp_m[4], last[4], errc[4], wrapc[4], outv[4];

  function automatic int msk(int w);
    return (1 << w) - 1;
  endfunction

  function automatic int sval(int k, int s);
    if (cfg_s[k] != 0 && s >= (1 << (cfg_w[k] - 1))) return s - (1 << cfg_w[k]);
    return s;
  endfunction

  function automatic int sat(int k, int x);
    return (x > msk(cfg_cw[k])) ? msk(cfg_cw[k]) : x;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      based[k] = 0; lk[k] = 0; errp[k] = 0; wrapp[k] = 0;
      run[k] = 0; exp_m[k] = 0; last[k] = 0; errc[k] = 0; wrapc[k] = 0; outv[k] = 0;
    end
  endtask

  task automatic model_step(int k, int s);
    bit wrap_now;
    if (!based[k]) begin
      based[k] = 1; run[k] = 0; lk[k] = (cfg_lc[k] == 1);
    end else if (s == exp_m[k]) begin
      if (lk[k]) begin
        if (cfg_s[k] != 0) wrap_now = (sval(k, last[k]) >= 0) && (sval(k, s) < 0);
        else               wrap_now = (s < last[k]);
        if (wrap_now) begin
          wrapp[k] = 1; wrapc[k] = sat(k, wrapc[k] + 1);
        end
      end else begin
        run[k]++;
        if (run[k] >= cfg_lc[k]) lk[k] = 1;
      end
    end else begin
      if (lk[k]) begin
        errp[k] = 1; errc[k] = sat(k, errc[k] + 1); lk[k] = 0;
      end
      run[k] = 0;
    end
    exp_m[k] = (s + cfg_st[k]) & msk(cfg_w[k]);
    last[k]  = s;
    outv[k]  = sval(k, s) & msk(cfg_ow[k]);
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("locked[%0d]", k),      o_lk[k], 32'(lk[k]));
      chk($sformatf("error_pulse[%0d]", k), o_ep[k], 32'(errp[k]));
      chk($sformatf("wrap_pulse[%0d]", k),  o_wp[k], 32'(wrapp[k]));
      chk($sformatf("error_count[%0d]", k), o_ec[k], 32'(errc[k]));
      chk($sformatf("wrap_count[%0d]", k),  o_wc[k], 32'(wrapc[k]));
      chk($sformatf("out_value[%0d]", k),   o_ov[k], 32'(outv[k]));
      chk($sformatf("expected[%0d]", k),    o_ex[k], 32'(exp_m[k]));
    end
  endtask

  function automatic int good(int k);
    return based[k] ? exp_m[k] : 0;
  endfunction

  task automatic step(bit v, int a, int b, int c, int d);
    int vals[4];
    vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = d;
    sample_valid = v;
    da = a[15:0]; db = b[3:0]; dc = c[2:0]; dd = d[7:0];
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      errp[k] = 0; wrapp[k] = 0;
      if (v) model_step(k, vals[k] & msk(cfg_w[k]));
    end
    check_all();
  endtask

  initial begin
    int b_err_seen;
    int bad;
    bit v;
    int r[4];

    model_reset();
    #1 reset = 1'b0;
    #2 check_all();
    @(negedge clk);
    check_all();
    reset = 1'b1;

    // Counting streams: A 0..16, B -8..7,-8, C 0..7,0.., D steps of 5.
    for (int i = 0; i <= 16; i++) begin
      step(1'b1, i, i - 8, i, 5 * i);
      if (i == 0) chk("t3_out_neg8", o_ov[1], 32'h3F8);
      if (i == 2) chk("t1_not_yet_locked", o_lk[0], 0);
      if (i == 3) chk("t1_locked", o_lk[0], 1);
      if (i == 8) chk("t2_wrap_pulse", o_wp[2], 1);
      if (i == 9) begin
        chk("t1_expected", o_ex[0], 10);
        chk("t1_err_cnt", o_ec[0], 0);
        chk("t2_wrap_cnt", o_wc[2], 1);
        chk("t2_err_cnt", o_ec[2], 0);
      end
      if (i == 16) chk("t3_wrap_pulse", o_wp[1], 1);
    end

    step(1'b0, 99, 3, 5, 1);
    chk("idle_cycle_pulse", o_wp[2], 0);

    for (int i = 17; i <= 20; i++) step(1'b1, i, good(1), good(2), good(3));
    chk("t4_pre_locked", o_lk[0], 1);
    step(1'b1, 25, good(1), good(2), good(3));
    chk("t4_err_pulse", o_ep[0], 1);
    chk("t4_unlocked", o_lk[0], 0);
    chk("t4_err_cnt", o_ec[0], 1);
    step(1'b1, 26, good(1), good(2), good(3));
    step(1'b1, 27, good(1), good(2), good(3));
    chk("t4_still_acquiring", o_lk[0], 0);
    step(1'b1, 28, good(1), good(2), good(3));
    chk("t4_relocked", o_lk[0], 1);

    b_err_seen = 0;
    for (int e = 0; e < 5; e++) begin
      bad = (exp_m[1] + 5) & 15;
      step(1'b1, good(0), bad, good(2), good(3));
      if (o_ep[1] == 1) b_err_seen++;
      for (int j = 0; j < 3; j++) step(1'b1, good(0), good(1), good(2), good(3));
      chk("t5_relock", o_lk[1], 1);
    end
    chk("t5_err_cnt_sat", o_ec[1], 3);
    chk("t5_pulses_seen", b_err_seen, 5);

    for (int n = 0; n < 600; n++) begin
      v = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++)
        r[k] = (!based[k] || $urandom_range(0, 9) == 0) ? int'($urandom) : exp_m[k];
      step(v, r[0], r[1], r[2], r[3]);
    end

    for (int j = 0; j < 5; j++) step(1'b1, good(0), good(1), good(2), good(3));
    chk("t6_pre_locked", o_lk[0], 1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("t6_async_locked", o_lk[0], 0);
    check_all();
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 100, 2, 3, 4);
    chk("t6_acquire_not_locked", o_lk[0], 0);
    chk("t6_expected", o_ex[0], 101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
